// File: rtl/asm_endereco_atual_pkg.sv
// rtl/asm_endereco_atual_pkg.sv - shared constants and state encoding for the playback address generator
// Purpose : default geometry, seek amounts in seconds, time_adder width and FSM state type.
package asm_endereco_atual_pkg;

   localparam int ADDR_W_DEF      = 22;
   localparam int SAMPLE_RATE_DEF = 8000;
   localparam int SEEK_SHORT_S    = 10;
   localparam int SEEK_LONG_S     = 30;
   localparam int TIME_W          = 9;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_PLAY = 2'd1,
      ST_END  = 2'd2
   } state_e;

endpackage

// File: rtl/asm_endereco_atual_btn_edge.sv
// rtl/asm_endereco_atual_btn_edge.sv - rising-edge detector for the seek buttons
// Purpose : one-cycle pulse per button press (btn & ~history).
// Ports   : clk, reset (sync, active-high), btn_i[W] button levels, rise_o[W] press pulses.
module btn_edge_detect #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] btn_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] hist_q;

   // History clears in reset so a button held across reset release reads as a fresh press.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= '0;
      end else begin
         hist_q <= btn_i;
      end
   end

   assign rise_o = btn_i & ~hist_q;

endmodule

// File: rtl/asm_endereco_atual.sv
// rtl/asm_endereco_atual.sv - playback address generator with seek buttons and end-of-song detection
// Purpose : advances the PCM address while playing, applies +/-10 s and +/-30 s seeks,
//           pulses prox_musica on end marker (PCM byte 0) or address exhaustion.
// Ports   : clk, reset (sync, active-high), count (1=play), passa_10s/volta_10s/
//           passa_30s/volta_30s (button levels), current_value[8] (PCM byte at endereco),
//           endereco[ADDR_W] (registered address), time_adder[9] signed seconds pulse,
//           prox_musica next-track pulse.
module asm_endereco_atual
   import asm_endereco_atual_pkg::*;
#(
   parameter int SAMPLE_RATE = SAMPLE_RATE_DEF,
   parameter int ADDR_W      = ADDR_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     count,
   input  logic                     passa_10s,
   input  logic                     volta_10s,
   input  logic                     passa_30s,
   input  logic                     volta_30s,
   input  logic [7:0]               current_value,
   output logic [ADDR_W-1:0]        endereco,
   output logic signed [TIME_W-1:0] time_adder,
   output logic                     prox_musica
);

   // One extra bit so forward overflow is visible in the sum.
   localparam logic [ADDR_W:0] MAX_ADDR   = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0] STEP_SHORT = (ADDR_W+1)'(SEEK_SHORT_S * SAMPLE_RATE);
   localparam logic [ADDR_W:0] STEP_LONG  = (ADDR_W+1)'(SEEK_LONG_S * SAMPLE_RATE);
   localparam logic signed [TIME_W-1:0] SECS_SHORT = TIME_W'(SEEK_SHORT_S);
   localparam logic signed [TIME_W-1:0] SECS_LONG  = TIME_W'(SEEK_LONG_S);

   state_e                     state_q;
   logic [ADDR_W-1:0]          endereco_q;
   logic signed [TIME_W-1:0]   time_adder_q;
   logic                       prox_q;

   logic [3:0]                 btn_edge;
   logic [ADDR_W:0]            addr_ext;
   logic [ADDR_W:0]            seek_calc;
   logic                       seek_hit;
   logic                       seek_ok;
   logic [ADDR_W-1:0]          seek_addr;
   logic signed [TIME_W-1:0]   seek_secs;

   btn_edge_detect #(.W(4)) u_btn_edge (
      .clk    (clk),
      .reset  (reset),
      .btn_i  ({passa_30s, volta_30s, passa_10s, volta_10s}),
      .rise_o (btn_edge)
   );

   // Highest-priority edge wins; if that seek is out of range the cycle is still a
   // seek cycle (no increment) but nothing is applied.
   always_comb begin
      addr_ext  = {1'b0, endereco_q};
      seek_hit  = |btn_edge;
      seek_ok   = 1'b0;
      seek_calc = addr_ext;
      seek_secs = '0;
      if (btn_edge[3]) begin
         seek_calc = addr_ext + STEP_LONG;
         seek_ok   = (seek_calc <= MAX_ADDR);
         seek_secs = SECS_LONG;
      end else if (btn_edge[2]) begin
         seek_calc = addr_ext - STEP_LONG;
         seek_ok   = (addr_ext >= STEP_LONG);
         seek_secs = -SECS_LONG;
      end else if (btn_edge[1]) begin
         seek_calc = addr_ext + STEP_SHORT;
         seek_ok   = (seek_calc <= MAX_ADDR);
         seek_secs = SECS_SHORT;
      end else if (btn_edge[0]) begin
         seek_calc = addr_ext - STEP_SHORT;
         seek_ok   = (addr_ext >= STEP_SHORT);
         seek_secs = -SECS_SHORT;
      end
      seek_addr = seek_calc[ADDR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_STOP;
         endereco_q   <= '0;
         time_adder_q <= '0;
         prox_q       <= 1'b0;
      end else begin
         time_adder_q <= '0;
         prox_q       <= 1'b0;
         case (state_q)
            ST_STOP: begin
               if (seek_ok) begin
                  endereco_q   <= seek_addr;
                  time_adder_q <= seek_secs;
               end
               state_q <= count ? ST_PLAY : ST_STOP;
            end
            ST_PLAY: begin
               if (current_value == 8'd0) begin
                  state_q    <= ST_END;
                  endereco_q <= '0;
                  prox_q     <= 1'b1;
               end else if (seek_hit) begin
                  if (seek_ok) begin
                     endereco_q   <= seek_addr;
                     time_adder_q <= seek_secs;
                  end
                  state_q <= count ? ST_PLAY : ST_STOP;
               end else if (!count) begin
                  state_q <= ST_STOP;
               end else if (endereco_q == MAX_ADDR[ADDR_W-1:0]) begin
                  // Last address played: finish the track instead of wrapping.
                  state_q    <= ST_END;
                  endereco_q <= '0;
                  prox_q     <= 1'b1;
               end else begin
                  endereco_q <= endereco_q + 1'b1;
               end
            end
            ST_END: begin
               state_q <= count ? ST_PLAY : ST_STOP;
            end
            default: begin
               state_q <= ST_STOP;
            end
         endcase
      end
   end

   assign endereco    = endereco_q;
   assign time_adder  = time_adder_q;
   assign prox_musica = prox_q;

endmodule

// File: tb/tb_asm_endereco_atual.sv
// tb/tb_asm_endereco_atual.sv - scoreboard bench for the playback address generator
module tb_asm_endereco_atual;

   localparam int SR = 4;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic count = 1'b0;
   logic passa_10s = 1'b0;
   logic volta_10s = 1'b0;
   logic passa_30s = 1'b0;
   logic volta_30s = 1'b0;
   logic [7:0] current_value = 8'd11;
   logic [AW-1:0] endereco;
   logic signed [8:0] time_adder;
   logic prox_musica;

   typedef struct {
      int   addr;
      int   secs;
      logic px;
   } exp_t;

   exp_t sb[$];
   int tests = 0;
   int fails = 0;

   asm_endereco_atual #(.SAMPLE_RATE(SR), .ADDR_W(AW)) dut (
      .clk           (clk),
      .reset         (reset),
      .count         (count),
      .passa_10s     (passa_10s),
      .volta_10s     (volta_10s),
      .passa_30s     (passa_30s),
      .volta_30s     (volta_30s),
      .current_value (current_value),
      .endereco      (endereco),
      .time_adder    (time_adder),
      .prox_musica   (prox_musica)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs at negedge; expected outputs after the next posedge go to the queue.
   // b = {passa_30s, volta_30s, passa_10s, volta_10s}
   task automatic cyc(input logic r, input logic c, input logic [3:0] b, input logic [7:0] v,
                      input int ea, input int es, input logic ep);
      exp_t e;
      @(negedge clk);
      reset = r;
      count = c;
      {passa_30s, volta_30s, passa_10s, volta_10s} = b;
      current_value = v;
      e.addr = ea;
      e.secs = es;
      e.px   = ep;
      sb.push_back(e);
   endtask

   // Monitor: every output cycle that has an expectation queued is compared.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (int'(endereco) != e.addr) begin
               fails++;
               $display("FAIL endereco: got %0d expected %0d at %0t", endereco, e.addr, $time);
            end
            tests++;
            if (int'(time_adder) != e.secs) begin
               fails++;
               $display("FAIL time_adder: got %0d expected %0d at %0t", time_adder, e.secs, $time);
            end
            tests++;
            if (prox_musica !== e.px) begin
               fails++;
               $display("FAIL prox_musica: got %0b expected %0b at %0t", prox_musica, e.px, $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. reset then count from 0
      for (int i = 0; i < 3; i++) cyc(1, 1, 4'b0000, 8'd11, 0, 0, 0);
      cyc(0, 1, 4'b0000, 8'd11, 0, 0, 0);
      for (int i = 1; i <= 5; i++) cyc(0, 1, 4'b0000, 8'd11, i, 0, 0);

      // 2. held passa_10s acts once, then volta_10s
      cyc(0, 1, 4'b0010, 8'd11, 45, 10, 0);
      for (int i = 1; i <= 9; i++) cyc(0, 1, 4'b0010, 8'd11, 45 + i, 0, 0);
      cyc(0, 1, 4'b0000, 8'd11, 55, 0, 0);
      cyc(0, 1, 4'b0001, 8'd11, 15, -10, 0);
      cyc(0, 1, 4'b0000, 8'd11, 16, 0, 0);

      // 3. pause, resume, reset held
      for (int i = 0; i < 3; i++) cyc(0, 0, 4'b0000, 8'd11, 16, 0, 0);
      cyc(0, 1, 4'b0000, 8'd11, 16, 0, 0);
      cyc(0, 1, 4'b0000, 8'd11, 17, 0, 0);
      cyc(0, 1, 4'b0000, 8'd11, 18, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 4'b0000, 8'd11, 0, 0, 0);

      // 4. backward underflow ignored, 30 s seeks (paused)
      cyc(0, 0, 4'b0000, 8'd11, 0, 0, 0);
      cyc(0, 0, 4'b0001, 8'd11, 0, 0, 0);
      cyc(0, 0, 4'b0000, 8'd11, 0, 0, 0);
      cyc(0, 0, 4'b1000, 8'd11, 120, 30, 0);
      cyc(0, 0, 4'b0000, 8'd11, 120, 0, 0);
      cyc(0, 0, 4'b0100, 8'd11, 0, -30, 0);
      cyc(0, 0, 4'b0000, 8'd11, 0, 0, 0);
      cyc(0, 0, 4'b0100, 8'd11, 0, 0, 0);
      cyc(0, 0, 4'b0000, 8'd11, 0, 0, 0);

      // 5. end marker while playing, ignored while paused
      cyc(0, 1, 4'b0000, 8'd11, 0, 0, 0);
      for (int i = 1; i <= 3; i++) cyc(0, 1, 4'b0000, 8'd11, i, 0, 0);
      cyc(0, 1, 4'b0000, 8'd0, 0, 0, 1);
      cyc(0, 1, 4'b0000, 8'd0, 0, 0, 0);
      cyc(0, 1, 4'b0000, 8'd0, 0, 0, 1);
      cyc(0, 1, 4'b0000, 8'd11, 0, 0, 0);
      cyc(0, 1, 4'b0000, 8'd11, 1, 0, 0);
      cyc(0, 1, 4'b0000, 8'd11, 2, 0, 0);
      cyc(0, 0, 4'b0000, 8'd11, 2, 0, 0);
      cyc(0, 0, 4'b0000, 8'd0, 2, 0, 0);
      cyc(0, 0, 4'b0000, 8'd0, 2, 0, 0);

      // 6. priority, forward overflow ignored, end of address space
      cyc(0, 0, 4'b1001, 8'd11, 122, 30, 0);
      cyc(0, 0, 4'b0000, 8'd11, 122, 0, 0);
      cyc(0, 0, 4'b1000, 8'd11, 242, 30, 0);
      cyc(0, 0, 4'b0000, 8'd11, 242, 0, 0);
      cyc(0, 0, 4'b0010, 8'd11, 242, 0, 0);
      cyc(0, 0, 4'b0000, 8'd11, 242, 0, 0);
      cyc(0, 1, 4'b0000, 8'd11, 242, 0, 0);
      for (int a = 243; a <= 255; a++) cyc(0, 1, 4'b0000, 8'd11, a, 0, 0);
      cyc(0, 1, 4'b0000, 8'd11, 0, 0, 1);
      cyc(0, 1, 4'b0000, 8'd11, 0, 0, 0);
      cyc(0, 1, 4'b0000, 8'd11, 1, 0, 0);

      // button held through reset release counts as a new press
      cyc(1, 0, 4'b1000, 8'd11, 0, 0, 0);
      cyc(0, 0, 4'b1000, 8'd11, 120, 30, 0);
      cyc(0, 0, 4'b0000, 8'd11, 120, 0, 0);

      @(negedge clk);
      @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
